// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

   localparam logic MODE_TOGGLE   = 1'b0;
   localparam logic MODE_PULSE    = 1'b1;
   localparam int   DEFAULT_CNT_W = 32;

   // Channel-select width; a single channel still needs a 1-bit select.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, programmable divisor/mode, registered out_clk and tick.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned             CNT_W       = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0]        DEFAULT_DIV = CNT_W'(50000)
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_div,
   input  logic             i_load_mode,
   output logic             o_out_clk,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_div;
   logic             r_mode;
   logic             r_out_clk;
   logic             r_tick;
   logic             w_terminal;

   // div==0 is excluded here and handled as the idle case below.
   assign w_terminal = (r_div != '0) && (r_count == r_div - CNT_W'(1));

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count   <= '0;
         r_div     <= DEFAULT_DIV;
         r_mode    <= MODE_TOGGLE;
         r_out_clk <= 1'b0;
         r_tick    <= 1'b0;
      end else if (i_load) begin
         r_div     <= i_load_div;
         r_mode    <= i_load_mode;
         r_count   <= '0;
         r_out_clk <= 1'b0;
         r_tick    <= 1'b0;
      end else if (i_sync || (r_div == '0)) begin
         r_count   <= '0;
         r_out_clk <= 1'b0;
         r_tick    <= 1'b0;
      end else if (!i_en) begin
         r_tick <= 1'b0;
         if (r_mode == MODE_PULSE)
            r_out_clk <= 1'b0;
      end else if (w_terminal) begin
         r_count   <= '0;
         r_tick    <= 1'b1;
         r_out_clk <= (r_mode == MODE_PULSE) ? 1'b1 : ~r_out_clk;
      end else begin
         r_count <= r_count + CNT_W'(1);
         r_tick  <= 1'b0;
         if (r_mode == MODE_PULSE)
            r_out_clk <= 1'b0;
      end
   end

   assign o_out_clk = r_out_clk;
   assign o_tick    = r_tick;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent runtime-programmable dividers behind a single config write port.
module multi_channel_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int unsigned      NUM_CH      = 4,
   parameter int unsigned      CNT_W       = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50000),
   parameter int unsigned      CH_W        = ch_width(NUM_CH)
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [NUM_CH-1:0] i_en,
   input  logic              i_sync,
   input  logic              i_cfg_valid,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [CNT_W-1:0]  i_cfg_div,
   input  logic              i_cfg_mode,
   output logic              o_cfg_err,
   output logic [NUM_CH-1:0] o_out_clk,
   output logic [NUM_CH-1:0] o_tick
);

   logic [NUM_CH-1:0] w_load;
   logic              w_bad_ch;
   logic              r_cfg_err;

   // Extra bit keeps the compare meaningful when NUM_CH is a power of two.
   assign w_bad_ch = i_cfg_valid && ({1'b0, i_cfg_ch} >= (CH_W+1)'(NUM_CH));

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         r_cfg_err <= 1'b0;
      else
         r_cfg_err <= w_bad_ch;
   end

   assign o_cfg_err = r_cfg_err;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_load[i] = i_cfg_valid && (i_cfg_ch == CH_W'(i));

      clkdiv_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .i_clock     (i_clock),
         .i_reset_n   (i_reset_n),
         .i_en        (i_en[i]),
         .i_sync      (i_sync),
         .i_load      (w_load[i]),
         .i_load_div  (i_cfg_div),
         .i_load_mode (i_cfg_mode),
         .o_out_clk   (o_out_clk[i]),
         .o_tick      (o_tick[i])
      );
   end

endmodule
